// File: rtl/uart_tx_fifo_mm.sv
// Avalon-MM transmit FIFO slave feeding uart_txd over a valid/ready handshake.
// Firmware queues bytes via TXDATA and can inspect STATUS/COUNT and control flush/enable via CTRL.
module uart_tx_fifo_mm #(
  parameter int DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [3:0] avs_address_i,
  input  logic       avs_read_i,
  input  logic       avs_write_i,
  input  logic [7:0] avs_writedata_i,
  output logic [7:0] avs_readdata_o,
  output logic       valid_o,
  output logic [7:0] data_o,
  input  logic       ready_i
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  localparam logic [3:0] ADDR_TXDATA = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h1;
  localparam logic [3:0] ADDR_COUNT  = 4'h2;
  localparam logic [3:0] ADDR_CTRL   = 4'h3;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          tx_enable;

  logic          empty;
  logic          full;
  logic          pop;
  logic          wr_txdata;
  logic          wr_ctrl;
  logic          flush;
  logic          ovf_clear;
  logic          push;
  logic          ovf_set;
  logic [AW-1:0] wr_ptr_next;
  logic [AW-1:0] rd_ptr_next;
  logic [CW-1:0] count_next;
  logic          overflow_next;
  logic          tx_enable_next;
  logic [7:0]    rd_value;

  assign empty   = (count == {CW{1'b0}});
  assign full    = (count == DEPTH_C);
  assign valid_o = !empty && tx_enable;
  assign data_o  = empty ? 8'h00 : mem[rd_ptr];
  assign pop     = valid_o && ready_i;

  // Decode bus writes into push, flush and overflow events.
  always_comb begin
    wr_txdata = avs_write_i && (avs_address_i == ADDR_TXDATA);
    wr_ctrl   = avs_write_i && (avs_address_i == ADDR_CTRL);
    flush     = wr_ctrl && avs_writedata_i[0];
    ovf_clear = wr_ctrl && avs_writedata_i[1];
    // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
    push      = wr_txdata && (!full || pop) && !flush;
    ovf_set   = wr_txdata && full && !pop && !flush;
  end

  // Next-state computation for pointers, occupancy and control flags.
  always_comb begin
    wr_ptr_next    = wr_ptr;
    rd_ptr_next    = rd_ptr;
    count_next     = count;
    overflow_next  = overflow;
    tx_enable_next = tx_enable;
    if (flush) begin
      wr_ptr_next = {AW{1'b0}};
      rd_ptr_next = {AW{1'b0}};
      count_next  = {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr + PTR_ONE;
      end else begin
        wr_ptr_next = wr_ptr;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr + PTR_ONE;
      end else begin
        rd_ptr_next = rd_ptr;
      end
      case ({push, pop})
        2'b10:   count_next = count + CNT_ONE;
        2'b01:   count_next = count - CNT_ONE;
        default: count_next = count;
      endcase
    end
    if (ovf_set) begin
      overflow_next = 1'b1;
    end else if (ovf_clear) begin
      overflow_next = 1'b0;
    end else begin
      overflow_next = overflow;
    end
    if (wr_ctrl) begin
      tx_enable_next = avs_writedata_i[2];
    end else begin
      tx_enable_next = tx_enable;
    end
  end

  // Register read mux over pre-update state.
  always_comb begin
    rd_value = 8'h00;
    case (avs_address_i)
      ADDR_TXDATA: rd_value = 8'h00;
      ADDR_STATUS: rd_value = {4'b0000, !ready_i, overflow, full, empty};
      ADDR_COUNT:  rd_value = 8'(count);
      ADDR_CTRL:   rd_value = {5'b00000, tx_enable, 2'b00};
      default:     rd_value = 8'h00;
    endcase
  end

  // Control/status state and registered read data.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr         <= {AW{1'b0}};
      rd_ptr         <= {AW{1'b0}};
      count          <= {CW{1'b0}};
      overflow       <= 1'b0;
      tx_enable      <= 1'b1;
      avs_readdata_o <= 8'h00;
    end else begin
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      count     <= count_next;
      overflow  <= overflow_next;
      tx_enable <= tx_enable_next;
      if (avs_read_i) begin
        avs_readdata_o <= rd_value;
      end else begin
        avs_readdata_o <= avs_readdata_o;
      end
    end
  end

  // Storage array; contents are only observable through a valid count, so no reset.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && push) begin
      mem[wr_ptr] <= avs_writedata_i;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_mm.sv
// Self-checking bench for uart_tx_fifo_mm: queue scoreboard for FIFO traffic plus directed register reads.
module tb_uart_tx_fifo_mm;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rst_n;
  logic [3:0] avs_address;
  logic       avs_read;
  logic       avs_write;
  logic [7:0] avs_writedata;
  logic [7:0] avs_readdata;
  logic       valid;
  logic [7:0] data;
  logic       ready;

  int total = 0;
  int bad   = 0;

  logic [7:0] model_q[$];
  logic       model_ovf   = 1'b0;
  logic       model_txen  = 1'b1;
  logic [7:0] model_rdata = 8'h00;
  logic       model_ok    = 1'b0;

  uart_tx_fifo_mm #(.DEPTH(DEPTH)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .avs_address_i   (avs_address),
    .avs_read_i      (avs_read),
    .avs_write_i     (avs_write),
    .avs_writedata_i (avs_writedata),
    .avs_readdata_o  (avs_readdata),
    .valid_o         (valid),
    .data_o          (data),
    .ready_i         (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: check outputs against the model, then advance the model to the next edge.
  always @(negedge clk) begin
    logic       exp_valid;
    logic       is_flush;
    logic       is_ctrl;
    logic       pop_now;
    logic [7:0] status;
    if (model_ok) begin
      exp_valid = (model_q.size() > 0) && model_txen;
      check_val("valid", {31'd0, valid}, {31'd0, exp_valid});
      check_val("data", {24'd0, data}, (model_q.size() > 0) ? {24'd0, model_q[0]} : 32'd0);
      check_val("readdata", {24'd0, avs_readdata}, {24'd0, model_rdata});
    end else begin
      exp_valid = 1'b0;
    end
    if (!rst_n) begin
      model_q.delete();
      model_ovf   = 1'b0;
      model_txen  = 1'b1;
      model_rdata = 8'h00;
      model_ok    = 1'b1;
    end else if (model_ok) begin
      if (avs_read) begin
        status = {4'b0000, !ready, model_ovf, (model_q.size() == DEPTH), (model_q.size() == 0)};
        case (avs_address)
          4'h1:    model_rdata = status;
          4'h2:    model_rdata = 8'(model_q.size());
          4'h3:    model_rdata = {5'b00000, model_txen, 2'b00};
          default: model_rdata = 8'h00;
        endcase
      end
      is_ctrl  = avs_write && (avs_address == 4'h3);
      is_flush = is_ctrl && avs_writedata[0];
      pop_now  = exp_valid && ready && !is_flush;
      if (is_flush) begin
        model_q.delete();
      end else begin
        if (pop_now) begin
          void'(model_q.pop_front());
        end
        if (avs_write && (avs_address == 4'h0)) begin
          if ((model_q.size() < DEPTH) || pop_now) begin
            model_q.push_back(avs_writedata);
          end else begin
            model_ovf = 1'b1;
          end
        end
      end
      if (is_ctrl) begin
        if (avs_writedata[1] && !(avs_write && avs_address == 4'h0 && model_q.size() == DEPTH && !pop_now)) begin
          model_ovf = 1'b0;
        end
        model_txen = avs_writedata[2];
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    avs_write     = 1'b1;
    avs_address   = a;
    avs_writedata = d;
    @(posedge clk);
    #1;
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] v);
    avs_read    = 1'b1;
    avs_address = a;
    @(posedge clk);
    #1;
    avs_read = 1'b0;
    v = avs_readdata;
  endtask

  initial begin
    logic [7:0] v;
    rst_n = 1'b0; ready = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
    avs_address = 4'h0; avs_writedata = 8'h00;
    idle(3);
    check_val("rst_readdata", {24'd0, avs_readdata}, 32'h00);
    check_val("rst_valid", {31'd0, valid}, 32'd0);
    check_val("rst_data", {24'd0, data}, 32'h00);
    rst_n = 1'b1;

    ready = 1'b1;
    rd(4'h1, v); check_val("rst_status", {24'd0, v}, 32'h01);
    rd(4'h2, v); check_val("rst_count", {24'd0, v}, 32'h00);
    ready = 1'b0;
    rd(4'h1, v); check_val("status_busy", {24'd0, v}, 32'h09);

    wr(4'h0, 8'h48); wr(4'h0, 8'h65); wr(4'h0, 8'h6C);
    rd(4'h2, v); check_val("count3", {24'd0, v}, 32'h03);
    check_val("valid3", {31'd0, valid}, 32'd1);
    check_val("head48", {24'd0, data}, 32'h48);
    ready = 1'b1; idle(1); ready = 1'b0;
    check_val("head65", {24'd0, data}, 32'h65);
    rd(4'h2, v); check_val("count2", {24'd0, v}, 32'h02);
    ready = 1'b1; idle(3); ready = 1'b0;
    rd(4'h2, v); check_val("count_drained", {24'd0, v}, 32'h00);

    for (int i = 0; i < DEPTH + 1; i++) wr(4'h0, 8'(8'h10 + i));
    rd(4'h2, v); check_val("count_full", {24'd0, v}, DEPTH);
    rd(4'h1, v); check_val("status_full_ovf", {24'd0, v}, 32'h0E);
    wr(4'h3, 8'h06);
    rd(4'h1, v); check_val("status_ovf_clr", {24'd0, v}, 32'h0A);
    rd(4'h3, v); check_val("ctrl_txen", {24'd0, v}, 32'h04);

    ready = 1'b1; wr(4'h0, 8'hA5); ready = 1'b0;
    rd(4'h2, v); check_val("count_full_pushpop", {24'd0, v}, DEPTH);
    rd(4'h1, v); check_val("status_no_ovf", {24'd0, v}, 32'h0A);

    ready = 1'b1; idle(DEPTH - 5); ready = 1'b0;
    rd(4'h2, v); check_val("count5", {24'd0, v}, 32'h05);
    ready = 1'b1; wr(4'h3, 8'h05); ready = 1'b0;
    check_val("flush_valid", {31'd0, valid}, 32'd0);
    rd(4'h2, v); check_val("flush_count", {24'd0, v}, 32'h00);
    rd(4'h1, v); check_val("flush_status", {24'd0, v}, 32'h09);

    wr(4'h3, 8'h00);
    ready = 1'b1;
    wr(4'h0, 8'h31); wr(4'h0, 8'h32);
    check_val("disabled_valid", {31'd0, valid}, 32'd0);
    rd(4'h2, v); check_val("disabled_count", {24'd0, v}, 32'h02);
    wr(4'h3, 8'h04);
    check_val("reenable_head", {24'd0, data}, 32'h31);
    idle(4); ready = 1'b0;
    rd(4'h2, v); check_val("reenable_drained", {24'd0, v}, 32'h00);

    wr(4'h5, 8'hFF);
    rd(4'h5, v); check_val("unmapped_rd", {24'd0, v}, 32'h00);
    rd(4'h0, v); check_val("txdata_rd", {24'd0, v}, 32'h00);
    rd(4'h2, v); check_val("unmapped_wr_count", {24'd0, v}, 32'h00);

    wr(4'h0, 8'hC1); wr(4'h0, 8'hC2); wr(4'h3, 8'h00);
    rst_n = 1'b0; idle(1); rst_n = 1'b1;
    check_val("midrst_valid", {31'd0, valid}, 32'd0);
    rd(4'h2, v); check_val("midrst_count", {24'd0, v}, 32'h00);
    rd(4'h3, v); check_val("midrst_ctrl", {24'd0, v}, 32'h04);
    idle(2);

    check_val("sb_empty", model_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_mm.md
Name: uart_tx_fifo_mm

Overview:
- Avalon-MM slave with an integrated transmit FIFO. It sits directly upstream of uart_txd inside uart_core and replaces the single-byte slave_mm.
- Software can queue up to DEPTH bytes without polling per character. The FIFO head is presented to uart_txd over a valid/ready handshake (ready driven from uart_txd rts).
- Status and count registers let firmware check occupancy and detect overflow.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..128.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset; synchronous, active-low.
- avs_address_i  in  4  register address.
- avs_read_i  in  1  read strobe.
- avs_write_i  in  1  write strobe.
- avs_writedata_i  in  8  write data.
- avs_readdata_o  out  8  read data, registered.
- valid_o  out  1  FIFO head valid toward uart_txd ena.
- data_o  out  8  FIFO head byte.
- ready_i  in  1  uart_txd rts; high = transmitter can accept a byte.

Behaviour:
- Reset (rst_n_i low at a clk_i edge) produces:
  - FIFO empty, count 0, read/write pointers 0.
  - overflow flag 0, tx_enable 1.
  - avs_readdata_o 0, valid_o 0, data_o 0.
- Register map; unlisted addresses read 0 and ignore writes.
  - 0x0 TXDATA:
    - Write pushes avs_writedata_i into the FIFO.
    - Read returns 0.
  - 0x1 STATUS (read-only):
    - bit0 empty, bit1 full, bit2 overflow (sticky), bit3 tx_busy (= !ready_i). Bits 7:4 read 0.
  - 0x2 COUNT (read-only): occupancy 0..DEPTH, zero-extended.
  - 0x3 CTRL:
    - Write: bit0 flush (self-clearing pulse), bit1 clear overflow (pulse), bit2 tx_enable (stored).
    - Read returns {5'b0, tx_enable, 2'b0}.
- Read timing:
  - avs_readdata_o updates one cycle after avs_read_i is sampled and holds until the next read.
  - Read values reflect register state before any same-edge update.
  - Simultaneous read and write are both honoured.
- Push rules:
  - A write to TXDATA is accepted if count < DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set. The FIFO is unchanged.
- Output handshake:
  - valid_o = !empty && tx_enable, combinational from registered state.
  - data_o = mem[rd_ptr] whenever non-empty, else 0.
  - A pop occurs on a clk_i edge where valid_o && ready_i; rd_ptr advances and count decrements.
  - valid_o never depends on ready_i.
  - Data written to an empty FIFO appears on valid_o/data_o the next cycle (1-cycle latency).
- Pointers:
  - Width log2(DEPTH). They wrap modulo DEPTH.
  - Count width log2(DEPTH)+1.
  - Push and pop in the same cycle leave count unchanged.
- Flush:
  - Flush sets count and both pointers to 0 and wins over any same-cycle push or pop.
  - A push discarded by flush does not set overflow.
  - Overflow set and clear in the same cycle: set wins.
- tx_enable:
  - While 0, valid_o is held low and the FIFO keeps filling normally.
  - Re-enabling resumes from the current head.
- Reset mid-operation: all state returns to reset values on the first edge with rst_n_i low. Bytes queued or in the FIFO are lost; uart_txd handles its own in-flight byte.

Test Plan:
- Reset, then read 0x1 and 0x2 → STATUS 0x01 (bit3 reflects ready_i), COUNT 0x00; valid_o 0.
- ready_i held 0; write 0x48,0x65,0x6C to 0x0 → COUNT 3, valid_o 1, data_o 0x48. Raise ready_i for one cycle → data_o 0x65, COUNT 2.
- ready_i 0; write DEPTH+1 bytes → COUNT 16, STATUS bit1=1 and bit2=1, the 17th byte is absent. Write 0x3=0x06 → bit2 clears, tx_enable kept 1.
- FIFO full, ready_i 1, TXDATA write in the same cycle → pop and push both occur, COUNT stays 16, no overflow.
- 5 bytes queued; write 0x3=0x05 (flush, tx_enable=1) with a simultaneous pop → COUNT 0, empty 1, valid_o 0 the next cycle.
- Write 0x3=0x00, then queue 2 bytes with ready_i 1 → valid_o stays 0 and COUNT 2. Write 0x3=0x04 → bytes drain in order, one per ready cycle.
